brew_arbiter: RTL

- Shares one physical brew unit (Coffee, Water, Cream and Sugar valves) between NUM_REQ vending front panels.
- Each panel raises a request with a recipe code. The arbiter grants one panel at a time using round-robin.
- It sequences the valve phases with fixed-duration timers, then returns a one-cycle Done pulse to the granted panel.
- Sits between the panel controllers and the valve drivers. It replaces direct valve drive from the panels.

---
 rtl/brew_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/brew_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/brew_pkg.sv
// Shared definitions for the brew unit arbiter: FSM state encoding, recipe
// codes and phase timer width.
package brew_pkg;

  localparam int TW = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BREW  = 3'd1,
    ST_CREAM = 3'd2,
    ST_SUGAR = 3'd3,
    ST_DONE  = 3'd4
  } brew_state_t;

  localparam logic [1:0] RCP_NONE        = 2'b00;
  localparam logic [1:0] RCP_BLACK       = 2'b01;
  localparam logic [1:0] RCP_CREAM       = 2'b10;
  localparam logic [1:0] RCP_CREAM_SUGAR = 2'b11;

  // Timer load value so that a phase lasts exactly t cycles.
  function automatic logic [TW-1:0] phase_load(input int t);
    return TW'(t - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past ptr and wraps,
// so the most recently served panel has the lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [1:0]         winner_idx,
  output logic               any_valid
);

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_valid && eligible[j] && (((int'(ptr) + k) % NUM_REQ) == j)) begin
          winner_oh[j] = 1'b1;
          winner_idx   = 2'(j);
          any_valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/brew_arbiter.sv
// Shares one brew unit between NUM_REQ panels: round-robin grant, timed valve
// phases (brew, cream, sugar) and a one-cycle Done pulse to the winner.
module brew_arbiter
  import brew_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int T_BREW  = 4,
  parameter int T_CREAM = 2,
  parameter int T_SUGAR = 2
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [2*NUM_REQ-1:0]   Recipe,
  output logic [NUM_REQ-1:0]     Grant,
  output logic [NUM_REQ-1:0]     Done,
  output logic                   Coffee,
  output logic                   Water,
  output logic                   Cream,
  output logic                   Sugar,
  output logic                   Busy
);

  brew_state_t          state, state_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [1:0]           rcp, rcp_nxt;
  logic [1:0]           ptr, ptr_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   win_oh;
  logic [1:0]           win_idx;
  logic [1:0]           win_rcp;
  logic                 any_valid;

  // A request carrying recipe 00 is not a job and never competes.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = Req[i] && (Recipe[2*i +: 2] != RCP_NONE);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible   (eligible),
    .ptr        (ptr),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any_valid  (any_valid)
  );

  always_comb begin
    win_rcp = RCP_NONE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_rcp = Recipe[2*i +: 2];
    end
  end

  // Only the recipe latched at grant time steers the phase sequence.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    rcp_nxt   = rcp;
    ptr_nxt   = ptr;
    grant_nxt = Grant;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          state_nxt = ST_BREW;
          timer_nxt = phase_load(T_BREW);
          rcp_nxt   = win_rcp;
          ptr_nxt   = win_idx;
          grant_nxt = win_oh;
        end
      end
      ST_BREW: begin
        if (timer == '0) begin
          if (rcp == RCP_BLACK) begin
            state_nxt = ST_DONE;
            timer_nxt = '0;
          end else begin
            state_nxt = ST_CREAM;
            timer_nxt = phase_load(T_CREAM);
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      ST_CREAM: begin
        if (timer == '0) begin
          if (rcp == RCP_CREAM_SUGAR) begin
            state_nxt = ST_SUGAR;
            timer_nxt = phase_load(T_SUGAR);
          end else begin
            state_nxt = ST_DONE;
            timer_nxt = '0;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      ST_SUGAR: begin
        if (timer == '0) begin
          state_nxt = ST_DONE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= ST_IDLE;
      timer  <= '0;
      rcp    <= RCP_NONE;
      ptr    <= '0;
      Grant  <= '0;
      Done   <= '0;
      Coffee <= 1'b0;
      Water  <= 1'b0;
      Cream  <= 1'b0;
      Sugar  <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      rcp    <= rcp_nxt;
      ptr    <= ptr_nxt;
      Grant  <= grant_nxt;
      Done   <= (state_nxt == ST_DONE) ? grant_nxt : '0;
      Coffee <= (state_nxt == ST_BREW);
      Water  <= (state_nxt == ST_BREW);
      Cream  <= (state_nxt == ST_CREAM);
      Sugar  <= (state_nxt == ST_SUGAR);
      Busy   <= (state_nxt != ST_IDLE);
    end
  end

endmodule
